// File: rtl/gf_dom_pkg.sv
// gf_dom_pkg
//   Shared helpers for the DOM-indep masked GF(2^2) multiplier.
//   - npairs(shares)          : number of unordered share pairs (randomness words per lane)
//   - pair_idx(shares, i, j)  : lexicographic index of pair (i,j), i<j
//   - sh_base(lanes, s, l)    : bit offset of the 2-bit slice for share s, lane l
//   - GF2_ONE                 : multiplicative identity in normal basis [Omega^2, Omega]
package gf_dom_pkg;

  localparam logic [1:0] GF2_ONE = 2'b11;

  function automatic int npairs(input int shares);
    return (shares * (shares - 1)) / 2;
  endfunction

  // Pairs ordered (0,1),(0,2),...,(0,n-1),(1,2),... ; caller guarantees i<j.
  function automatic int pair_idx(input int shares, input int i, input int j);
    return i * shares - (i * (i + 1)) / 2 + (j - i - 1);
  endfunction

  function automatic int sh_base(input int lanes, input int s, input int l);
    return (s * lanes + l) * 2;
  endfunction

endpackage

// File: rtl/gf_mul2_nb.sv
// gf_mul2_nb
//   Combinational GF(2^2) multiplier, normal basis [Omega^2, Omega].
// Ports
//   x_i  in  2  first operand
//   y_i  in  2  second operand
//   p_o  out 2  product x*y
module gf_mul2_nb (
  input  logic [1:0] x_i,
  input  logic [1:0] y_i,
  output logic [1:0] p_o
);

  logic t_s;

  // Shared term from the sums of both coordinates.
  assign t_s = (x_i[1] ^ x_i[0]) & (y_i[1] ^ y_i[0]);
  assign p_o = {(x_i[1] & y_i[1]) ^ t_s, (x_i[0] & y_i[0]) ^ t_s};

endmodule

// File: rtl/gf_mul2_dom_pipe.sv
// gf_mul2_dom_pipe
//   Two-stage pipelined DOM-indep masked GF(2^2) multiplier, LANES independent
//   products of SHARES-share operands, valid/ready stream on both sides.
//   Stage 1 registers every inner term A_i*B_i and every re-masked cross term
//   A_i*B_j ^ Z_ij separately; stage 2 compresses them into the output shares.
// Parameters
//   SHARES  Boolean shares per operand (2..4)
//   LANES   parallel multiplications per transfer (1..8)
// Ports
//   clk, rst             clock, synchronous active-high reset
//   in_valid / in_ready  input handshake (in_ready depends only on state and out_ready)
//   a_sh, b_sh           operand shares, slice [(s*LANES+l)*2 +: 2]
//   r_in                 fresh randomness, pair k slice [(k*LANES+l)*2 +: 2]
//   out_valid/out_ready  output handshake
//   q_sh                 product shares, same packing as a_sh
// Build option
//   GF_MUL_DOM_CLEAR_EN  when defined, a stage loading a bubble zeroes its data,
//                        so q_sh reads 0 whenever out_valid is low.
module gf_mul2_dom_pipe
  import gf_dom_pkg::*;
#(
  parameter int SHARES = 2,
  parameter int LANES  = 1
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic                                     in_valid,
  output logic                                     in_ready,
  input  logic [SHARES*LANES*2-1:0]                a_sh,
  input  logic [SHARES*LANES*2-1:0]                b_sh,
  input  logic [npairs(SHARES)*LANES*2-1:0]        r_in,
  output logic                                     out_valid,
  input  logic                                     out_ready,
  output logic [SHARES*LANES*2-1:0]                q_sh
);

  localparam int DW = SHARES * LANES * 2;
  localparam int TW = SHARES * SHARES * LANES * 2;

  // Stage-1 term bank: slot ((i*SHARES+j)*LANES+l)*2; diagonal = inner, off-diagonal = cross.
  logic [TW-1:0] term_s;
  logic [TW-1:0] s1_d, s1_q;
  logic          s1_v_d, s1_v_q;
  logic [DW-1:0] sum_s;
  logic [DW-1:0] s2_d, s2_q;
  logic          s2_v_d, s2_v_q;
  logic          s1_load_s, s2_load_s;

  for (genvar i = 0; i < SHARES; i++) begin : g_i
    for (genvar j = 0; j < SHARES; j++) begin : g_j
      for (genvar l = 0; l < LANES; l++) begin : g_l
        localparam int AI = sh_base(LANES, i, l);
        localparam int BJ = sh_base(LANES, j, l);
        localparam int TI = ((i * SHARES + j) * LANES + l) * 2;
        logic [1:0] prod_s;

        gf_mul2_nb u_mul (
          .x_i (a_sh[AI +: 2]),
          .y_i (b_sh[BJ +: 2]),
          .p_o (prod_s)
        );

        if (i == j) begin : g_inner
          assign term_s[TI +: 2] = prod_s;
        end else begin : g_cross
          // Z_ij and Z_ji are the same randomness word so it cancels in the share sum.
          localparam int K = (i < j) ? pair_idx(SHARES, i, j) : pair_idx(SHARES, j, i);
          assign term_s[TI +: 2] = prod_s ^ r_in[(K * LANES + l) * 2 +: 2];
        end
      end
    end
  end

  // Share i of the product is the XOR of row i of the registered term bank.
  always_comb begin
    sum_s = '0;
    for (int i = 0; i < SHARES; i++) begin
      for (int j = 0; j < SHARES; j++) begin
        for (int l = 0; l < LANES; l++) begin
          sum_s[(i * LANES + l) * 2 +: 2] = sum_s[(i * LANES + l) * 2 +: 2]
                                          ^ s1_q[((i * SHARES + j) * LANES + l) * 2 +: 2];
        end
      end
    end
  end

  assign s2_load_s = ~s2_v_q | out_ready;
  assign s1_load_s = ~s1_v_q | s2_load_s;
  assign in_ready  = s1_load_s;

  // Next-state for both stages: valid bits follow upstream on load, data per build option.
  always_comb begin
    s1_v_d = s1_v_q;
    s2_v_d = s2_v_q;
    s1_d   = s1_q;
    s2_d   = s2_q;
    if (s1_load_s) begin
      s1_v_d = in_valid;
    end
    if (s2_load_s) begin
      s2_v_d = s1_v_q;
    end
`ifdef GF_MUL_DOM_CLEAR_EN
    if (s1_load_s) begin
      s1_d = in_valid ? term_s : '0;
    end
    if (s2_load_s) begin
      s2_d = s1_v_q ? sum_s : '0;
    end
`else
    if (s1_load_s && in_valid) begin
      s1_d = term_s;
    end
    if (s2_load_s && s1_v_q) begin
      s2_d = sum_s;
    end
`endif
  end

  // Pipeline registers; reset discards anything in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_v_q <= 1'b0;
      s2_v_q <= 1'b0;
      s1_q   <= '0;
      s2_q   <= '0;
    end else begin
      s1_v_q <= s1_v_d;
      s2_v_q <= s2_v_d;
      s1_q   <= s1_d;
      s2_q   <= s2_d;
    end
  end

  assign out_valid = s2_v_q;
  assign q_sh      = s2_q;

endmodule

// File: tb/tb_gf_mul2_dom_pipe.sv
// Self-checking bench for gf_mul2_dom_pipe: a SHARES=2/LANES=1 instance for the
// hand-worked share-level sequences and a SHARES=3/LANES=4 instance for the
// table-driven product checks, back-pressure and reset.
module tb_gf_mul2_dom_pipe;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // SHARES=2, LANES=1 instance
  logic       v2, rdy2, ov2, ordy2;
  logic [3:0] a2, b2, q2;
  logic [1:0] r2;

  // SHARES=3, LANES=4 instance
  logic        v3, rdy3, ov3, ordy3;
  logic [23:0] a3, b3, q3, r3;

  gf_mul2_dom_pipe #(.SHARES(2), .LANES(1)) u_dut2 (
    .clk(clk), .rst(rst), .in_valid(v2), .in_ready(rdy2), .a_sh(a2), .b_sh(b2),
    .r_in(r2), .out_valid(ov2), .out_ready(ordy2), .q_sh(q2)
  );

  gf_mul2_dom_pipe #(.SHARES(3), .LANES(4)) u_dut3 (
    .clk(clk), .rst(rst), .in_valid(v3), .in_ready(rdy3), .a_sh(a3), .b_sh(b3),
    .r_in(r3), .out_valid(ov3), .out_ready(ordy3), .q_sh(q3)
  );

  typedef struct {
    logic [7:0] a;    // lane l at [2l+:2]
    logic [7:0] b;
    logic [7:0] exp;  // unmasked product per lane
  } vec_t;

  vec_t tbl [6];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   q_idx [$];
  int   idx;
  logic [23:0] cap;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] unmask3(input logic [23:0] q);
    return q[7:0] ^ q[15:8] ^ q[23:16];
  endfunction

  // Split A and B into three random shares each, with random Z words.
  task automatic drive3(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] s0, s1, t0, t1;
    s0 = 8'($urandom);
    s1 = 8'($urandom);
    t0 = 8'($urandom);
    t1 = 8'($urandom);
    a3 = {a ^ s0 ^ s1, s1, s0};
    b3 = {b ^ t0 ^ t1, t1, t0};
    r3 = 24'($urandom);
    v3 = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // All 16 (A,B) pairs: transfer k puts A=k in every lane, B=lane index.
    tbl[0] = '{a: 8'h00, b: 8'hE4, exp: 8'h00};
    tbl[1] = '{a: 8'h55, b: 8'hE4, exp: 8'h78};
    tbl[2] = '{a: 8'hAA, b: 8'hE4, exp: 8'h9C};
    tbl[3] = '{a: 8'hFF, b: 8'hE4, exp: 8'hE4};
    tbl[4] = '{a: 8'hAA, b: 8'h55, exp: 8'hFF};  // Omega^2 * Omega = 1
    tbl[5] = '{a: 8'h9E, b: 8'h5B, exp: 8'hEA};

    rst = 1'b1;
    v2 = 1'b0; ordy2 = 1'b1; a2 = 4'h0; b2 = 4'h0; r2 = 2'b00;
    v3 = 1'b0; ordy3 = 1'b1; a3 = 24'h0; b3 = 24'h0; r3 = 24'h0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("rst_ov2",  ov2,  1'b0);
    check("rst_q2",   q2,   4'h0);
    check("rst_rdy2", rdy2, 1'b1);
    check("rst_ov3",  ov3,  1'b0);
    check("rst_q3",   q3,   24'h0);
    check("rst_rdy3", rdy3, 1'b1);

    // A={11,01}=10, B={10,00}=10, Z=11; then same with Z=00, separated by a bubble.
    a2 = 4'b1101; b2 = 4'b1000; r2 = 2'b11; v2 = 1'b1;
    @(negedge clk);
    v2 = 1'b0;
    check("lat_ov_c1", ov2, 1'b0);
    @(negedge clk);
    check("lat_ov_c2", ov2, 1'b1);
    check("t1_shares", q2, 4'b0100);
    check("t1_xor",    q2[3:2] ^ q2[1:0], 2'b01);
    r2 = 2'b00; v2 = 1'b1;
    @(negedge clk);
    v2 = 1'b0;
    check("gap_ov", ov2, 1'b0);
`ifdef GF_MUL_DOM_CLEAR_EN
    check("gap_q_clear", q2, 4'b0000);
`else
    check("gap_q_hold",  q2, 4'b0100);
`endif
    @(negedge clk);
    check("t4_ov",     ov2, 1'b1);
    check("t4_shares", q2, 4'b1011);
    check("t4_xor",    q2[3:2] ^ q2[1:0], 2'b01);

    // Back-to-back stream through the table, both stages busy every cycle.
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (k >= 2) begin
        check("tbl_ov",  ov3, 1'b1);
        check("tbl_xor", unmask3(q3), tbl[k-2].exp);
      end
      if (k < 6) drive3(tbl[k].a, tbl[k].b);
      else       v3 = 1'b0;
    end
    @(negedge clk);
    check("tbl_idle_ov", ov3, 1'b0);

    // Back-pressure: out_ready low for 5 cycles with in_valid held high.
    ordy3 = 1'b0;
    idx = 0;
    cap = 24'h0;
    for (int c = 0; c < 5; c++) begin
      if (c > 0) @(negedge clk);
      drive3(tbl[idx].a, tbl[idx].b);
      #1;
      if (rdy3) begin
        q_idx.push_back(idx);
        idx++;
      end
      if (c == 2) cap = q3;
    end
    check("bp_accepted", q_idx.size(), 2);
    check("bp_rdy",      rdy3, 1'b0);
    check("bp_ov",       ov3, 1'b1);
    check("bp_stable",   q3, cap);
    check("bp_head",     unmask3(q3), tbl[0].exp);

    @(negedge clk);
    v3 = 1'b0;
    ordy3 = 1'b1;
    #1;
    for (int c = 0; c < 6 && q_idx.size() > 0; c++) begin
      if (ov3) begin
        check("drain_xor", unmask3(q3), tbl[q_idx[0]].exp);
        void'(q_idx.pop_front());
      end
      @(negedge clk);
      #1;
    end
    check("drain_left", q_idx.size(), 0);
    @(negedge clk);
    check("drain_empty_ov", ov3, 1'b0);

    // Fill both instances, then reset mid-stream.
    ordy3 = 1'b0; ordy2 = 1'b0;
    drive3(tbl[4].a, tbl[4].b);
    a2 = 4'b1101; b2 = 4'b1000; r2 = 2'b11; v2 = 1'b1;
    @(negedge clk);
    drive3(tbl[5].a, tbl[5].b);
    @(negedge clk);
    v3 = 1'b0; v2 = 1'b0;
    check("full_rdy3", rdy3, 1'b0);
    check("full_rdy2", rdy2, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mrst_ov3",  ov3,  1'b0);
    check("mrst_q3",   q3,   24'h0);
    check("mrst_rdy3", rdy3, 1'b1);
    check("mrst_ov2",  ov2,  1'b0);
    check("mrst_q2",   q2,   4'h0);
    check("mrst_rdy2", rdy2, 1'b1);
    ordy3 = 1'b1;
    drive3(tbl[3].a, tbl[3].b);
    @(negedge clk);
    v3 = 1'b0;
    check("post_rst_c1_ov", ov3, 1'b0);
    @(negedge clk);
    check("post_rst_c2_ov",  ov3, 1'b1);
    check("post_rst_c2_xor", unmask3(q3), tbl[3].exp);
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
